// File: rtl/sdram_responder.sv
// Behavioural SDRAM chip stand-in: decodes the 16-bit SDRAM command pins, keeps a small word
// array, returns read data at the programmed CAS latency and latches protocol/timing errors.
module sdram_responder #(
    parameter int ROW_W = 4,
    parameter int COL_W = 6,
    parameter int TRCD  = 2,
    parameter int TRP   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sd_ncs,
    input  logic        sd_nras,
    input  logic        sd_ncas,
    input  logic        sd_nwe,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_a,
    input  logic        sd_dqml,
    input  logic        sd_dqmh,
    input  logic [15:0] sd_dq_i,
    output logic [15:0] sd_dq_o,
    output logic        sd_dq_oe,
    output logic [4:0]  err,
    output logic [15:0] rfs_cnt,
    output logic        mode_ok
);
    localparam int AW    = 2 + ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = 4;

    typedef enum logic [2:0] {
        CMD_LMR  = 3'b000,
        CMD_REF  = 3'b001,
        CMD_PRE  = 3'b010,
        CMD_ACT  = 3'b011,
        CMD_WR   = 3'b100,
        CMD_RD   = 3'b101,
        CMD_BST  = 3'b110,
        CMD_NOP  = 3'b111
    } cmd_e;

    cmd_e              cmd;
    logic [3:0]        active_q, active_d;
    logic [ROW_W-1:0]  row_q [4];
    logic [ROW_W-1:0]  row_d [4];
    logic [CW-1:0]     trcd_q [4];
    logic [CW-1:0]     trcd_d [4];
    logic [CW-1:0]     trp_q [4];
    logic [CW-1:0]     trp_d [4];
    logic [4:0]        err_q, err_d;
    logic [15:0]       rfs_q, rfs_d;
    logic              mode_ok_q, mode_ok_d;
    logic              cl3_q, cl3_d;
    logic [1:0]        slot_vld_q, slot_vld_d;
    logic [15:0]       slot_dat_q [2];
    logic [15:0]       slot_dat_d [2];
    logic [15:0]       dq_o_q, dq_o_d;
    logic              oe_q, oe_d;
    logic              we_lo, we_hi, rd_en;
    logic [AW-1:0]     addr;
    logic [15:0]       rd_word;
    logic [7:0]        mem_lo [DEPTH];
    logic [7:0]        mem_hi [DEPTH];
    logic              unused_a;

    assign cmd      = sd_ncs ? CMD_NOP : cmd_e'({sd_nras, sd_ncas, sd_nwe});
    assign addr     = {sd_ba, row_q[sd_ba], sd_a[COL_W-1:0]};
    assign rd_word  = {mem_hi[addr], mem_lo[addr]};
    assign unused_a = ^sd_a;

    always_comb begin
        active_d   = active_q;
        row_d      = row_q;
        err_d      = err_q;
        rfs_d      = rfs_q;
        mode_ok_d  = mode_ok_q;
        cl3_d      = cl3_q;
        we_lo      = 1'b0;
        we_hi      = 1'b0;
        rd_en      = 1'b0;
        for (int b = 0; b < 4; b++) begin
            trcd_d[b] = (trcd_q[b] != '0) ? trcd_q[b] - CW'(1) : '0;
            trp_d[b]  = (trp_q[b]  != '0) ? trp_q[b]  - CW'(1) : '0;
        end
        case (cmd)
            CMD_ACT: begin
                if (active_q[sd_ba])      err_d[1] = 1'b1;
                if (trp_q[sd_ba] != '0)   err_d[3] = 1'b1;
                active_d[sd_ba] = 1'b1;
                row_d[sd_ba]    = sd_a[ROW_W-1:0];
                trcd_d[sd_ba]   = CW'(TRCD - 1);
            end
            CMD_RD, CMD_WR: begin
                if (!active_q[sd_ba]) err_d[1] = 1'b1;
                if (!mode_ok_q)       err_d[0] = 1'b1;
                // Read data reaches the pins at this edge: a write now collides with it.
                if (cmd == CMD_WR && slot_vld_q[0]) err_d[1] = 1'b1;
                if (active_q[sd_ba] && mode_ok_q) begin
                    if (trcd_q[sd_ba] != '0) err_d[2] = 1'b1;
                    if (cmd == CMD_WR) begin
                        we_lo = !sd_dqml;
                        we_hi = !sd_dqmh;
                    end else begin
                        rd_en = 1'b1;
                    end
                    if (sd_a[10]) begin
                        active_d[sd_ba] = 1'b0;
                        trp_d[sd_ba]    = CW'(TRP);
                    end
                end
            end
            CMD_PRE: begin
                for (int b = 0; b < 4; b++) begin
                    if (sd_a[10] || sd_ba == 2'(b)) begin
                        active_d[b] = 1'b0;
                        trp_d[b]    = CW'(TRP);
                    end
                end
            end
            CMD_REF: begin
                rfs_d = rfs_q + 16'd1;
                if (|active_q) err_d[4] = 1'b1;
            end
            CMD_LMR: begin
                if (|active_q) begin
                    err_d[4] = 1'b1;
                end else if ((sd_a[6:4] == 3'd2 || sd_a[6:4] == 3'd3) && sd_a[2:0] == 3'd0) begin
                    mode_ok_d = 1'b1;
                    cl3_d     = (sd_a[6:4] == 3'd3);
                end else begin
                    mode_ok_d = 1'b0;
                    err_d[4]  = 1'b1;
                end
            end
            default: ;
        endcase

        // Slot 0 feeds the pins next edge; CL=3 reads enter one slot further back.
        slot_vld_d[0] = (rd_en && !cl3_q) ? 1'b1 : slot_vld_q[1];
        slot_dat_d[0] = (rd_en && !cl3_q) ? rd_word : slot_dat_q[1];
        slot_vld_d[1] = rd_en && cl3_q;
        slot_dat_d[1] = rd_word;
        oe_d          = slot_vld_q[0];
        dq_o_d        = slot_vld_q[0] ? slot_dat_q[0] : dq_o_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= '0;
            err_q      <= '0;
            rfs_q      <= '0;
            mode_ok_q  <= 1'b0;
            cl3_q      <= 1'b0;
            slot_vld_q <= '0;
            oe_q       <= 1'b0;
            dq_o_q     <= '0;
            for (int b = 0; b < 4; b++) begin
                row_q[b]  <= '0;
                trcd_q[b] <= '0;
                trp_q[b]  <= '0;
            end
            slot_dat_q[0] <= '0;
            slot_dat_q[1] <= '0;
        end else begin
            active_q   <= active_d;
            err_q      <= err_d;
            rfs_q      <= rfs_d;
            mode_ok_q  <= mode_ok_d;
            cl3_q      <= cl3_d;
            slot_vld_q <= slot_vld_d;
            oe_q       <= oe_d;
            dq_o_q     <= dq_o_d;
            row_q      <= row_d;
            trcd_q     <= trcd_d;
            trp_q      <= trp_d;
            slot_dat_q <= slot_dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we_lo) mem_lo[addr] <= sd_dq_i[7:0];
        if (we_hi) mem_hi[addr] <= sd_dq_i[15:8];
    end

    assign sd_dq_o  = dq_o_q;
    assign sd_dq_oe = oe_q;
    assign err      = err_q;
    assign rfs_cnt  = rfs_q;
    assign mode_ok  = mode_ok_q;
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: commands driven on the falling edge, read returns
// checked by a queue-based monitor, status outputs checked directly from the stimulus.
module tb_sdram_responder;
    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sd_ncs = 1'b1, sd_nras = 1'b1, sd_ncas = 1'b1, sd_nwe = 1'b1;
    logic [1:0]  sd_ba = '0;
    logic [12:0] sd_a = '0;
    logic        sd_dqml = 1'b0, sd_dqmh = 1'b0;
    logic [15:0] sd_dq_i = '0;
    logic [15:0] sd_dq_o;
    logic        sd_dq_oe;
    logic [4:0]  err;
    logic [15:0] rfs_cnt;
    logic        mode_ok;

    typedef struct { logic [15:0] dat; int due; } exp_t;
    exp_t exp_q[$];
    int   cyc = 0, n_vec = 0, n_err = 0, cl_tb = 2;

    sdram_responder dut (
        .clk(clk), .rst_n(rst_n), .sd_ncs(sd_ncs), .sd_nras(sd_nras), .sd_ncas(sd_ncas),
        .sd_nwe(sd_nwe), .sd_ba(sd_ba), .sd_a(sd_a), .sd_dqml(sd_dqml), .sd_dqmh(sd_dqmh),
        .sd_dq_i(sd_dq_i), .sd_dq_o(sd_dq_o), .sd_dq_oe(sd_dq_oe), .err(err),
        .rfs_cnt(rfs_cnt), .mode_ok(mode_ok)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read-return monitor: each driven word must match the oldest expectation on its due cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_vec++; n_err++;
                $display("FAIL rd_missing: no drive, required 0x%04h at cycle %0d (now %0d)",
                         exp_q[0].dat, exp_q[0].due, cyc);
                void'(exp_q.pop_front());
            end
            if (sd_dq_oe) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: drive 0x%04h at cycle %0d, required none", sd_dq_o, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.dat !== sd_dq_o || e.due != cyc) begin
                        n_err++;
                        $display("FAIL rd_data: got 0x%04h at cycle %0d, required 0x%04h at cycle %0d",
                                 sd_dq_o, cyc, e.dat, e.due);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] d, input logic [1:0] m);
        @(negedge clk);
        sd_ncs = 1'b0;
        {sd_nras, sd_ncas, sd_nwe} = c;
        sd_ba = ba;
        sd_a = a;
        sd_dq_i = d;
        {sd_dqmh, sd_dqml} = m;
    endtask

    task automatic nop(input int n);
        repeat (n) cmd(C_NOP, 2'd0, 13'd0, 16'd0, 2'b00);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [12:0] a, input bit has_data, input logic [15:0] d);
        exp_t e;
        cmd(C_RD, ba, a, 16'd0, 2'b00);
        if (has_data) begin
            e.dat = d;
            e.due = cyc + cl_tb;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sd_ncs = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cl_tb = 2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_err", err, 0);
        chk("rst_mode_ok", mode_ok, 0);
        chk("rst_rfs", rfs_cnt, 0);
        chk("rst_oe", sd_dq_oe, 0);
        chk("rst_dq", sd_dq_o, 0);
        rst_n = 1'b1;

        // Power-up: NOPs, precharge all, two refreshes, mode CL=2 BL=1
        nop(8);
        cmd(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        cmd(C_REF, 2'd0, 13'h000, 16'd0, 2'b00);
        cmd(C_REF, 2'd0, 13'h000, 16'd0, 2'b00);
        cmd(C_LMR, 2'd0, 13'h220, 16'd0, 2'b00);
        nop(1);
        chk("init_mode_ok", mode_ok, 1);
        chk("init_rfs", rfs_cnt, 2);
        chk("init_err", err, 0);

        // Write with auto-precharge, reopen, read back
        cmd(C_ACT, 2'd1, 13'd5, 16'd0, 2'b00);
        nop(1);
        cmd(C_WR, 2'd1, 13'h403, 16'hA55A, 2'b00);
        nop(3);
        cmd(C_ACT, 2'd1, 13'd5, 16'd0, 2'b00);
        nop(1);
        rd(2'd1, 13'h003, 1'b1, 16'hA55A);
        nop(2);
        chk("wr_rd_err", err, 0);

        // High byte masked write, immediate readback
        cmd(C_WR, 2'd1, 13'h003, 16'h1234, 2'b10);
        rd(2'd1, 13'h003, 1'b1, 16'hA534);
        nop(2);

        // Back-to-back reads drive continuously
        cmd(C_WR, 2'd1, 13'h004, 16'hBEEF, 2'b00);
        rd(2'd1, 13'h003, 1'b1, 16'hA534);
        rd(2'd1, 13'h004, 1'b1, 16'hBEEF);
        rd(2'd1, 13'h003, 1'b1, 16'hA534);
        nop(4);
        chk("b2b_err", err, 0);

        // CL=3
        cmd(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        cmd(C_LMR, 2'd0, 13'h230, 16'd0, 2'b00);
        cl_tb = 3;
        nop(1);
        cmd(C_ACT, 2'd1, 13'd5, 16'd0, 2'b00);
        nop(1);
        rd(2'd1, 13'h003, 1'b1, 16'hA534);
        nop(5);
        chk("cl3_mode_ok", mode_ok, 1);
        chk("cl3_err", err, 0);

        // tRCD violation: data still returned
        cmd(C_ACT, 2'd2, 13'd7, 16'd0, 2'b00);
        nop(1);
        cmd(C_WR, 2'd2, 13'h401, 16'h5AA5, 2'b00);
        nop(3);
        cmd(C_ACT, 2'd2, 13'd7, 16'd0, 2'b00);
        rd(2'd2, 13'h001, 1'b1, 16'h5AA5);
        nop(5);
        chk("trcd_err", err, 5'h04);

        // Read to idle bank: dropped, no drive
        rd(2'd3, 13'h000, 1'b0, 16'h0000);
        nop(5);
        chk("idle_rd_err", err, 5'h06);

        // Illegal burst length
        cmd(C_PRE, 2'd0, 13'h400, 16'd0, 2'b00);
        cmd(C_LMR, 2'd0, 13'h221, 16'd0, 2'b00);
        nop(1);
        chk("bad_mode_ok", mode_ok, 0);
        chk("bad_mode_err", err, 5'h16);

        // Read before any mode load
        do_reset();
        chk("rst2_err", err, 0);
        cmd(C_ACT, 2'd0, 13'd0, 16'd0, 2'b00);
        nop(1);
        rd(2'd0, 13'h000, 1'b0, 16'h0000);
        nop(4);
        chk("nomode_err", err, 5'h01);
        chk("nomode_mode_ok", mode_ok, 0);

        // Reset while a read is still in the delay line
        do_reset();
        cmd(C_LMR, 2'd0, 13'h220, 16'd0, 2'b00);
        cmd(C_ACT, 2'd0, 13'd0, 16'd0, 2'b00);
        cmd(C_REF, 2'd0, 13'h000, 16'd0, 2'b00);
        cmd(C_WR, 2'd0, 13'h002, 16'h0F0F, 2'b00);
        rd(2'd0, 13'h002, 1'b1, 16'h0F0F);
        rd(2'd0, 13'h002, 1'b1, 16'h0F0F);
        @(negedge clk);
        chk("pre_rst_err", err, 5'h10);
        chk("pre_rst_rfs", rfs_cnt, 1);
        #2;
        rst_n = 1'b0;
        sd_ncs = 1'b1;
        exp_q.delete();
        #1;
        chk("async_rst_oe", sd_dq_oe, 0);
        chk("async_rst_err", err, 0);
        chk("async_rst_mode_ok", mode_ok, 0);
        repeat (3) @(negedge clk);
        chk("held_rst_oe", sd_dq_oe, 0);
        rst_n = 1'b1;
        nop(4);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
